// File: rtl/mult_pkg.sv
// Shared definitions for the 2x2 multiply-accumulate datapath.
// Contents:
//   PROD_W   - width of the multiplier product (2x2 -> 4 bits)
//   MAX_PROD - largest product the 2x2 multiplier can produce (3*3)
//   state_t  - two-state control encoding of the product accumulator
package mult_pkg;

  localparam int PROD_W   = 4;
  localparam int MAX_PROD = 9;

  typedef enum logic [0:0] {
    ACC  = 1'b0,   // collecting products
    HOLD = 1'b1    // group result pending on the output handshake
  } state_t;

endpackage : mult_pkg

// File: rtl/product_accumulator.sv
// Product accumulator: sums groups of products arriving over a valid/ready
// handshake and presents each group sum on an output valid/ready handshake.
// A group closes after COUNT products, or early on an accepted in_last.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous, active-high reset (discards any partial group)
//   in_valid  - in_prod/in_last valid this cycle
//   in_ready  - block accepts a product this cycle (ACC state, not in reset)
//   in_prod   - product, zero-extended when added
//   in_last   - accepted product closes the current group early
//   out_valid - group result available
//   out_ready - downstream consumes the result
//   out_sum   - group sum modulo 2^ACC_W
//   out_count - number of products in the group (1..COUNT)
//   out_ovf   - a carry out of ACC_W occurred during the group
module product_accumulator #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  import mult_pkg::*;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  state_t             w_state_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;
  logic               w_out_valid_nxt;
  logic [ACC_W-1:0]   w_out_sum_nxt;
  logic [CNT_W-1:0]   w_out_count_nxt;
  logic               w_out_ovf_nxt;

  logic               w_accept;
  logic               w_close;
  logic [ACC_W:0]     w_sum;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Ready depends only on state (and reset), never on in_valid.
  assign in_ready  = (r_state == ACC) && !rst;
  assign w_accept  = in_valid && in_ready;
  // One extra bit keeps the carry out of the accumulator visible.
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(in_prod);
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_close   = w_accept && ((r_cnt == CNT_W'(COUNT - 1)) || in_last);

  // Next-state and next-output logic for the ACC/HOLD controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;
    case (r_state)
      ACC: begin
        if (w_accept) begin
          w_acc_nxt = w_sum[ACC_W-1:0];
          w_cnt_nxt = w_cnt_inc;
          w_ovf_nxt = r_ovf | w_sum[ACC_W];
          if (w_close) begin
            w_state_nxt     = HOLD;
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = w_sum[ACC_W-1:0];
            w_out_count_nxt = w_cnt_inc;
            w_out_ovf_nxt   = r_ovf | w_sum[ACC_W];
          end else begin
            w_state_nxt = ACC;
          end
        end else begin
          w_state_nxt = ACC;
        end
      end
      HOLD: begin
        // Result registers stay put; only the accumulation state is cleared.
        if (out_ready) begin
          w_state_nxt     = ACC;
          w_out_valid_nxt = 1'b0;
          w_acc_nxt       = {ACC_W{1'b0}};
          w_cnt_nxt       = {CNT_W{1'b0}};
          w_ovf_nxt       = 1'b0;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt     = ACC;
        w_out_valid_nxt = 1'b0;
        w_acc_nxt       = {ACC_W{1'b0}};
        w_cnt_nxt       = {CNT_W{1'b0}};
        w_ovf_nxt       = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= {ACC_W{1'b0}};
      r_out_count <= {CNT_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default build (ACC_W=6) and a narrow
// build (ACC_W=4) share all inputs; each group result is compared with the
// true integer sum of the group reduced modulo 2^ACC_W.
module tb_product_accumulator;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_prod;
  logic       in_last;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_sum;
  logic [3:0] out_count;
  logic       out_ovf;

  logic       n_in_ready;
  logic       n_out_valid;
  logic [3:0] n_out_sum;
  logic [3:0] n_out_count;
  logic       n_out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(4), .COUNT(COUNT), .ACC_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  product_accumulator #(.PROD_W(4), .COUNT(COUNT), .ACC_W(4), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_sum(n_out_sum), .out_count(n_out_count),
    .out_ovf(n_out_ovf)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one product for one cycle; the block must be ready for it.
  task automatic send(input logic [3:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_in_ready got=%b want=1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = 4'd0;
  endtask

  // Consume a pending result and confirm the block returns to accepting.
  task automatic handshake();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake_release valid=%b ready=%b want valid=0 ready=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_prod = 4'd0; in_last = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 6'd0 ||
        out_count !== 4'd0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b v=%b sum=%0d cnt=%0d ovf=%b want 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 4; i++) send(4'd9, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 6'd36 || out_count !== 4'd4 ||
        out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_9x4 v=%b sum=%0d cnt=%0d ovf=%b rdy=%b want 1 36 4 0 0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    end
    total++;
    if (n_out_sum !== 4'd4 || n_out_ovf !== 1'b1) begin
      bad++;
      $display("FAIL full_9x4_narrow sum=%0d ovf=%b want 4 1", n_out_sum, n_out_ovf);
    end
    handshake();
  endtask

  task automatic test_last();
    send(4'd3, 1'b0);
    send(4'd2, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 6'd5 || out_count !== 4'd2) begin
      bad++;
      $display("FAIL last_3_2 v=%b sum=%0d cnt=%0d want 1 5 2", out_valid, out_sum, out_count);
    end
    handshake();
    for (int i = 0; i < 4; i++) send(4'd1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 4'd4) begin
      bad++;
      $display("FAIL after_last_1x4 v=%b sum=%0d cnt=%0d want 1 4 4", out_valid, out_sum, out_count);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send(4'd6, 1'b0);
    send(4'd6, 1'b1);
    in_valid = 1'b1;
    in_prod  = 4'd6;
    for (int i = 0; i < 5; i++) begin
      cycle();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 6'd12 || out_count !== 4'd2 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold c=%0d v=%b sum=%0d cnt=%0d rdy=%b want 1 12 2 0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
    end
    in_valid = 1'b0;
    in_prod  = 4'd0;
    handshake();
  endtask

  task automatic test_gapped();
    send(4'd9, 1'b0);
    cycle();
    cycle();
    send(4'd4, 1'b0);
    cycle();
    send(4'd1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL gapped_early_valid got=%b want=0", out_valid);
    end
    send(4'd2, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 6'd16 || out_count !== 4'd4 ||
        n_out_sum !== 4'd0 || n_out_ovf !== 1'b1) begin
      bad++;
      $display("FAIL gapped v=%b sum=%0d cnt=%0d nsum=%0d novf=%b want 1 16 4 0 1",
               out_valid, out_sum, out_count, n_out_sum, n_out_ovf);
    end
    handshake();
  endtask

  task automatic test_overflow_narrow();
    send(4'd9, 1'b0);
    send(4'd9, 1'b1);
    total++;
    if (n_out_valid !== 1'b1 || n_out_sum !== 4'd2 || n_out_ovf !== 1'b1 ||
        out_sum !== 6'd18 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_9_9 nv=%b nsum=%0d novf=%b sum=%0d ovf=%b want 1 2 1 18 0",
               n_out_valid, n_out_sum, n_out_ovf, out_sum, out_ovf);
    end
    handshake();
    send(4'd1, 1'b1);
    total++;
    if (n_out_sum !== 4'd1 || n_out_ovf !== 1'b0 || n_out_count !== 4'd1) begin
      bad++;
      $display("FAIL ovf_cleared nsum=%0d novf=%b ncnt=%0d want 1 0 1",
               n_out_sum, n_out_ovf, n_out_count);
    end
    handshake();
  endtask

  task automatic test_reset_mid_group();
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) send(4'd1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_count !== 4'd4 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_regroup v=%b sum=%0d cnt=%0d ovf=%b want 1 4 4 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    handshake();
  endtask

  // Random group lengths, early closes, idle gaps and output stalls.
  task automatic test_random();
    for (int g = 0; g < 40; g++) begin
      int len;
      int true_sum;
      len = $urandom_range(COUNT, 1);
      true_sum = 0;
      for (int k = 0; k < len; k++) begin
        logic [3:0] p;
        int gap;
        p = 4'($urandom_range(15, 0));
        gap = $urandom_range(2, 0);
        for (int j = 0; j < gap; j++) cycle();
        true_sum += int'(p);
        send(p, (k == len - 1) && (len < COUNT || $urandom_range(1, 0) == 1));
      end
      total++;
      if (out_valid !== 1'b1 || out_sum !== 6'(true_sum % 64) ||
          out_count !== 4'(len) || out_ovf !== (true_sum >= 64)) begin
        bad++;
        $display("FAIL random_wide g=%0d v=%b sum=%0d cnt=%0d ovf=%b want 1 %0d %0d %0d",
                 g, out_valid, out_sum, out_count, out_ovf, true_sum % 64, len,
                 (true_sum >= 64));
      end
      total++;
      if (n_out_valid !== 1'b1 || n_out_sum !== 4'(true_sum % 16) ||
          n_out_count !== 4'(len) || n_out_ovf !== (true_sum >= 16)) begin
        bad++;
        $display("FAIL random_narrow g=%0d v=%b sum=%0d cnt=%0d ovf=%b want 1 %0d %0d %0d",
                 g, n_out_valid, n_out_sum, n_out_count, n_out_ovf, true_sum % 16, len,
                 (true_sum >= 16));
      end
      begin
        int stall;
        stall = $urandom_range(3, 0);
        for (int j = 0; j < stall; j++) cycle();
      end
      total++;
      if (out_valid !== 1'b1 || out_sum !== 6'(true_sum % 64) || out_count !== 4'(len)) begin
        bad++;
        $display("FAIL random_stall_stable g=%0d v=%b sum=%0d cnt=%0d", g, out_valid,
                 out_sum, out_count);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_last();
    test_backpressure();
    test_gapped();
    test_overflow_narrow();
    test_reset_mid_group();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_product_accumulator
